// File: rtl/wr_arb_3x_to_2w_if.sv
// Bus bundle between the three write-back producers, the arbiter and the
// register-file write ports.
interface wr_arb_3x_to_2w_if #(
    parameter int WIDTH = 64
);
    logic [2:0]         src_valid;
    logic [2:0]         src_ready;
    logic [17:0]        src_addr;
    logic [3*WIDTH-1:0] src_data;
    logic               wr0_en;
    logic               wr1_en;
    logic [5:0]         wr0_addr;
    logic [5:0]         wr1_addr;
    logic [WIDTH-1:0]   wr0_data;
    logic [WIDTH-1:0]   wr1_data;
    logic               oor_err;
    logic               busy;

    modport master (
        output src_valid, src_addr, src_data,
        input  src_ready, wr0_en, wr1_en, wr0_addr, wr1_addr,
        input  wr0_data, wr1_data, oor_err, busy
    );

    modport slave (
        input  src_valid, src_addr, src_data,
        output src_ready, wr0_en, wr1_en, wr0_addr, wr1_addr,
        output wr0_data, wr1_data, oor_err, busy
    );
endinterface

// File: rtl/wr_arb_3x_to_2w.sv
// Three-source write-back arbiter: 2-deep FIFO per source, round-robin issue of
// up to two writes per cycle that never target the same register word.
module wr_arb_3x_to_2w #(
    parameter int WIDTH = 64
) (
    input logic               clk,
    input logic               rst,
    wr_arb_3x_to_2w_if.slave  bus
);
    localparam logic [5:0] ADDR_LIMIT = 6'd40;

    logic [5:0]       fifo_addr_r [3][2];
    logic [WIDTH-1:0] fifo_data_r [3][2];
    logic [1:0]       count_r [3];
    logic [2:0]       rd_ptr_r;
    logic [2:0]       wr_ptr_r;
    logic [1:0]       rr_ptr_r;

    logic             wr0_en_r, wr1_en_r, oor_err_r;
    logic [5:0]       wr0_addr_r, wr1_addr_r;
    logic [WIDTH-1:0] wr0_data_r, wr1_data_r;

    logic [5:0]       head_addr_s [3];
    logic [WIDTH-1:0] head_data_s [3];
    logic [2:0]       elig_s, ready_s, push_s, pop_s;
    logic             g0_vld_s, g1_vld_s, g0_oor_s, g1_oor_s;
    logic [1:0]       g0_idx_s, g1_idx_s, idx_s;

    // Modulo-3 advance of a round-robin index.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] ofs);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, ofs};
        if (sum >= 3'd3) begin
            return 2'(sum - 3'd3);
        end else begin
            return sum[1:0];
        end
    endfunction

    // FIFO head view, eligibility, and push qualification from registered counts.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            head_addr_s[i] = fifo_addr_r[i][rd_ptr_r[i]];
            head_data_s[i] = fifo_data_r[i][rd_ptr_r[i]];
            elig_s[i]      = (count_r[i] != 2'd0);
            ready_s[i]     = (count_r[i] < 2'd2);
            push_s[i]      = bus.src_valid[i] & ready_s[i];
        end
    end

    // Round-robin scan: slot 0 takes the first eligible head, slot 1 the next
    // eligible head further along the scan whose address differs.
    always_comb begin
        g0_vld_s = 1'b0;
        g1_vld_s = 1'b0;
        g0_idx_s = 2'd0;
        g1_idx_s = 2'd0;
        idx_s    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            idx_s = rr_idx(rr_ptr_r, 2'(k));
            if (!g0_vld_s && elig_s[idx_s]) begin
                g0_vld_s = 1'b1;
                g0_idx_s = idx_s;
            end else if (g0_vld_s && !g1_vld_s && elig_s[idx_s] &&
                         (head_addr_s[idx_s] != head_addr_s[g0_idx_s])) begin
                g1_vld_s = 1'b1;
                g1_idx_s = idx_s;
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // Pop every granted head; flag out-of-range grants.
    always_comb begin
        pop_s    = 3'b000;
        g0_oor_s = g0_vld_s && (head_addr_s[g0_idx_s] >= ADDR_LIMIT);
        g1_oor_s = g1_vld_s && (head_addr_s[g1_idx_s] >= ADDR_LIMIT);
        if (g0_vld_s) begin
            pop_s[g0_idx_s] = 1'b1;
        end else begin
            pop_s = 3'b000;
        end
        if (g1_vld_s) begin
            pop_s[g1_idx_s] = 1'b1;
        end else begin
            pop_s = pop_s;
        end
    end

    // FIFO storage; contents are only meaningful under count_r, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push_s[i]) begin
                fifo_addr_r[i][wr_ptr_r[i]] <= bus.src_addr[6*i +: 6];
                fifo_data_r[i][wr_ptr_r[i]] <= bus.src_data[WIDTH*i +: WIDTH];
            end
        end
    end

    // FIFO occupancy, pointers and round-robin position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                count_r[i] <= 2'd0;
            end
            rd_ptr_r <= 3'b000;
            wr_ptr_r <= 3'b000;
            rr_ptr_r <= 2'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                count_r[i] <= count_r[i] + {1'b0, push_s[i]} - {1'b0, pop_s[i]};
            end
            rd_ptr_r <= rd_ptr_r ^ pop_s;
            wr_ptr_r <= wr_ptr_r ^ push_s;
            if (g1_vld_s) begin
                rr_ptr_r <= rr_idx(g1_idx_s, 2'd1);
            end else if (g0_vld_s) begin
                rr_ptr_r <= rr_idx(g0_idx_s, 2'd1);
            end
        end
    end

    // Registered write ports; addr/data hold when the slot does not write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr0_en_r   <= 1'b0;
            wr1_en_r   <= 1'b0;
            wr0_addr_r <= 6'd0;
            wr1_addr_r <= 6'd0;
            wr0_data_r <= {WIDTH{1'b0}};
            wr1_data_r <= {WIDTH{1'b0}};
            oor_err_r  <= 1'b0;
        end else begin
            wr0_en_r  <= g0_vld_s && !g0_oor_s;
            wr1_en_r  <= g1_vld_s && !g1_oor_s;
            oor_err_r <= oor_err_r | g0_oor_s | g1_oor_s;
            if (g0_vld_s && !g0_oor_s) begin
                wr0_addr_r <= head_addr_s[g0_idx_s];
                wr0_data_r <= head_data_s[g0_idx_s];
            end
            if (g1_vld_s && !g1_oor_s) begin
                wr1_addr_r <= head_addr_s[g1_idx_s];
                wr1_data_r <= head_data_s[g1_idx_s];
            end
        end
    end

    assign bus.src_ready = ready_s;
    assign bus.busy      = |elig_s;
    assign bus.wr0_en    = wr0_en_r;
    assign bus.wr1_en    = wr1_en_r;
    assign bus.wr0_addr  = wr0_addr_r;
    assign bus.wr1_addr  = wr1_addr_r;
    assign bus.wr0_data  = wr0_data_r;
    assign bus.wr1_data  = wr1_data_r;
    assign bus.oor_err   = oor_err_r;
endmodule
